mem_access_unit: RTL and testbench

Memory-stage data-access unit of the five-stage RV32I pipeline. It sits between the EX/MEM register and the MEM/WB buffer. It turns the load/store in the MEM stage into a data-cache request and holds a stall request until the cache responds. It then presents the aligned, sign/zero-extended load word on `data_rdata_mem` and keeps that result stable across downstream stalls.

---
 rtl/mem_access_unit_pkg.sv | 29 ++
 rtl/mem_access_unit_if.sv | 23 ++
 rtl/mem_access_unit_load_align.sv | 25 ++
 rtl/mem_access_unit.sv | 121 ++++++++++++
 tb/tb_mem_access_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage data-access unit: word type, FSM states and funct3 codes.
package mem_access_unit_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned MBE_W = XLEN / 8;

   typedef logic [XLEN-1:0] rv32i_word;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } mem_state_t;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      SB = 3'b000,
      SH = 3'b001,
      SW = 3'b010
   } store_funct3_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-cache request/response bus between the MEM-stage unit (master) and the cache (slave).
interface mem_access_unit_if;
   import mem_access_unit_pkg::*;

   logic             data_read;
   logic             data_write;
   logic [MBE_W-1:0] data_mbe;
   rv32i_word        data_addr;
   rv32i_word        data_wdata;
   rv32i_word        data_rdata;
   logic             data_resp;

   modport master (
      output data_read, data_write, data_mbe, data_addr, data_wdata,
      input  data_rdata, data_resp
   );

   modport slave (
      input  data_read, data_write, data_mbe, data_addr, data_wdata,
      output data_rdata, data_resp
   );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// load_align: picks the addressed byte/half out of a cache word and sign/zero-extends it.
module mem_access_unit_load_align
   import mem_access_unit_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic [1:0] off,
   input  rv32i_word  rdata,
   output rv32i_word  result
);

   rv32i_word shifted;

   always_comb begin
      shifted = rdata >> {off, 3'b000};
      result  = rdata;
      case (funct3)
         LB:      result = {{24{shifted[7]}}, shifted[7:0]};
         LBU:     result = {24'b0, shifted[7:0]};
         LH:      result = {{16{shifted[15]}}, shifted[15:0]};
         LHU:     result = {16'b0, shifted[15:0]};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-access unit: issues cache requests, stalls until response, holds load result.
// Optional MEM_MISALIGN_CHECK_EN adds a misalign flag and suppresses misaligned requests.
module mem_access_unit
   import mem_access_unit_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_valid,
   input  logic               mem_load,
   input  logic               mem_store,
   input  logic [2:0]         funct3,
   input  rv32i_word          mem_addr,
   input  rv32i_word          mem_wdata,
   input  logic               advance,
   mem_access_unit_if.master  dbus,
   output rv32i_word          data_rdata_mem,
   output logic               mem_busy
`ifdef MEM_MISALIGN_CHECK_EN
   ,
   output logic               misalign
`endif
);

   mem_state_t state_q, state_d;
   rv32i_word  hold_q, hold_d;
   rv32i_word  load_word;
   logic [1:0] off;
   logic       is_mem_op;
   logic       bad_align;
   logic       access;
   logic       req_phase;

   assign off       = mem_addr[1:0];
   assign is_mem_op = mem_valid & (mem_load | mem_store);

`ifdef MEM_MISALIGN_CHECK_EN
   assign bad_align = ((funct3[1:0] == 2'b01) & off[0]) |
                      ((funct3[1:0] == 2'b10) & (off != 2'b00));
   assign misalign  = ~rst & is_mem_op & bad_align;
`else
   assign bad_align = 1'b0;
`endif

   assign access = is_mem_op & ~bad_align;

   mem_access_unit_load_align u_load_align (
      .funct3 (funct3),
      .off    (off),
      .rdata  (dbus.data_rdata),
      .result (load_word)
   );

   // Next state, hold capture and stall/result outputs; a response is only honoured in WAIT.
   always_comb begin
      state_d        = state_q;
      hold_d         = hold_q;
      req_phase      = 1'b0;
      mem_busy       = 1'b0;
      data_rdata_mem = hold_q;
      case (state_q)
         IDLE: begin
            req_phase = access;
            mem_busy  = access;
            if (access && advance) state_d = WAIT;
         end
         WAIT: begin
            req_phase = 1'b1;
            mem_busy  = ~dbus.data_resp;
            if (dbus.data_resp) begin
               hold_d         = mem_load ? load_word : '0;
               data_rdata_mem = hold_d;
               state_d        = advance ? IDLE : HOLD;
            end
         end
         HOLD: begin
            if (advance) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if ((state_q == IDLE) && is_mem_op && bad_align) data_rdata_mem = '0;
      if (rst) begin
         req_phase      = 1'b0;
         mem_busy       = 1'b0;
         data_rdata_mem = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   assign dbus.data_read  = req_phase & mem_load;
   assign dbus.data_write = req_phase & mem_store;
   assign dbus.data_addr  = {mem_addr[31:2], 2'b00};

   // Store lane placement; loads and words use all four byte enables.
   always_comb begin
      dbus.data_mbe   = 4'b1111;
      dbus.data_wdata = mem_wdata;
      if (mem_store) begin
         case (funct3)
            SB: begin
               dbus.data_mbe   = 4'b0001 << off;
               dbus.data_wdata = {24'b0, mem_wdata[7:0]} << {off, 3'b000};
            end
            SH: begin
               dbus.data_mbe   = 4'b0011 << off;
               dbus.data_wdata = {16'b0, mem_wdata[15:0]} << {off, 3'b000};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (optionally with MEM_MISALIGN_CHECK_EN).
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, mem_load, mem_store, advance;
   logic [2:0]  funct3;
   logic [31:0] mem_addr, mem_wdata, data_rdata_mem;
   logic        mem_busy;
`ifdef MEM_MISALIGN_CHECK_EN
   logic        misalign;
`endif
   int          errors = 0;
   int          checks = 0;

   mem_access_unit_if dbus ();

   mem_access_unit dut (
      .clk            (clk),
      .rst            (rst),
      .mem_valid      (mem_valid),
      .mem_load       (mem_load),
      .mem_store      (mem_store),
      .funct3         (funct3),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .advance        (advance),
      .dbus           (dbus),
      .data_rdata_mem (data_rdata_mem),
      .mem_busy       (mem_busy)
`ifdef MEM_MISALIGN_CHECK_EN
      ,
      .misalign       (misalign)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1);
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
      mem_valid = v; mem_load = ld; mem_store = st; funct3 = f3; mem_addr = a; mem_wdata = wd;
   endtask

   task automatic test_reset();
      rst = 1'b1; advance = 1'b1; dbus.data_resp = 1'b0; dbus.data_rdata = 32'h0;
      set_op(1, 1, 0, 3'b010, 32'h100, 32'h0);
      next_cycle(); #2;
      checks++; if (dbus.data_read !== 1'b0) begin errors++; $display("FAIL rst_read got=%b exp=0", dbus.data_read); end
      checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", mem_busy); end
      checks++; if (data_rdata_mem !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", data_rdata_mem); end
      next_cycle(); rst = 1'b0; set_op(0, 0, 0, 3'b000, 32'h0, 32'h0); #2;
      checks++; if (mem_busy !== 1'b0 || dbus.data_read !== 1'b0 || dbus.data_write !== 1'b0) begin
         errors++; $display("FAIL bubble_idle got=%b%b%b exp=000", mem_busy, dbus.data_read, dbus.data_write); end
      checks++; if (data_rdata_mem !== 32'h0) begin errors++; $display("FAIL rst_hold got=%h exp=0", data_rdata_mem); end
   endtask

   task automatic test_lw();
      next_cycle(); set_op(1, 1, 0, 3'b010, 32'h100, 32'h0); #2;
      checks++; if (dbus.data_read !== 1'b1 || dbus.data_write !== 1'b0) begin
         errors++; $display("FAIL lw_req got=%b%b exp=10", dbus.data_read, dbus.data_write); end
      checks++; if (dbus.data_addr !== 32'h100 || dbus.data_mbe !== 4'hF) begin
         errors++; $display("FAIL lw_addr got=%h/%h exp=100/f", dbus.data_addr, dbus.data_mbe); end
      checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL lw_busy0 got=%b exp=1", mem_busy); end
      for (int i = 1; i < 3; i++) begin
         next_cycle(); #2;
         checks++; if (mem_busy !== 1'b1 || dbus.data_read !== 1'b1) begin
            errors++; $display("FAIL lw_wait%0d got=%b%b exp=11", i, mem_busy, dbus.data_read); end
      end
      next_cycle(); dbus.data_resp = 1'b1; dbus.data_rdata = 32'hDEADBEEF; #2;
      checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL lw_resp_busy got=%b exp=0", mem_busy); end
      checks++; if (dbus.data_read !== 1'b1) begin errors++; $display("FAIL lw_resp_read got=%b exp=1", dbus.data_read); end
      checks++; if (data_rdata_mem !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got=%h exp=deadbeef", data_rdata_mem); end
      next_cycle(); dbus.data_resp = 1'b0; dbus.data_rdata = 32'h0; set_op(0, 0, 0, 3'b000, 32'h0, 32'h0); #2;
      checks++; if (mem_busy !== 1'b0 || dbus.data_read !== 1'b0) begin
         errors++; $display("FAIL lw_idle got=%b%b exp=00", mem_busy, dbus.data_read); end
      checks++; if (data_rdata_mem !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_hold got=%h exp=deadbeef", data_rdata_mem); end
   endtask

   task automatic test_lb_lbu();
      logic [2:0]  f3  [2] = '{3'b000, 3'b100};
      logic [31:0] exp [2] = '{32'hFFFFFF80, 32'h00000080};
      for (int i = 0; i < 2; i++) begin
         next_cycle(); set_op(1, 1, 0, f3[i], 32'h103, 32'h0); #2;
         checks++; if (dbus.data_addr !== 32'h100) begin errors++; $display("FAIL lb%0d_addr got=%h exp=100", i, dbus.data_addr); end
         next_cycle(); dbus.data_resp = 1'b1; dbus.data_rdata = 32'h80000000; #2;
         checks++; if (data_rdata_mem !== exp[i]) begin errors++; $display("FAIL lb%0d_data got=%h exp=%h", i, data_rdata_mem, exp[i]); end
         next_cycle(); dbus.data_resp = 1'b0; dbus.data_rdata = 32'h0; set_op(0, 0, 0, 3'b000, 32'h0, 32'h0); #2;
         checks++; if (data_rdata_mem !== exp[i]) begin errors++; $display("FAIL lb%0d_hold got=%h exp=%h", i, data_rdata_mem, exp[i]); end
      end
   endtask

   task automatic test_store();
      logic [2:0]  f3  [3] = '{3'b001, 3'b000, 3'b010};
      logic [31:0] ad  [3] = '{32'h202, 32'h201, 32'h304};
      logic [31:0] wd  [3] = '{32'h0000ABCD, 32'h12345678, 32'h12345678};
      logic [3:0]  emb [3] = '{4'b1100, 4'b0010, 4'b1111};
      logic [31:0] ewd [3] = '{32'hABCD0000, 32'h00007800, 32'h12345678};
      logic [31:0] ead [3] = '{32'h200, 32'h200, 32'h304};
      for (int i = 0; i < 3; i++) begin
         next_cycle(); set_op(1, 0, 1, f3[i], ad[i], wd[i]); #2;
         checks++; if (dbus.data_write !== 1'b1 || dbus.data_read !== 1'b0) begin
            errors++; $display("FAIL st%0d_req got=%b%b exp=10", i, dbus.data_write, dbus.data_read); end
         checks++; if (dbus.data_mbe !== emb[i]) begin errors++; $display("FAIL st%0d_mbe got=%b exp=%b", i, dbus.data_mbe, emb[i]); end
         checks++; if (dbus.data_wdata !== ewd[i]) begin errors++; $display("FAIL st%0d_wdata got=%h exp=%h", i, dbus.data_wdata, ewd[i]); end
         checks++; if (dbus.data_addr !== ead[i]) begin errors++; $display("FAIL st%0d_addr got=%h exp=%h", i, dbus.data_addr, ead[i]); end
         next_cycle(); dbus.data_resp = 1'b1; dbus.data_rdata = 32'hFFFFFFFF; #2;
         checks++; if (data_rdata_mem !== 32'h0 || dbus.data_write !== 1'b1) begin
            errors++; $display("FAIL st%0d_resp got=%h/%b exp=0/1", i, data_rdata_mem, dbus.data_write); end
         next_cycle(); dbus.data_resp = 1'b0; dbus.data_rdata = 32'h0; set_op(0, 0, 0, 3'b000, 32'h0, 32'h0); #2;
         checks++; if (dbus.data_write !== 1'b0 || mem_busy !== 1'b0) begin
            errors++; $display("FAIL st%0d_idle got=%b%b exp=00", i, dbus.data_write, mem_busy); end
      end
   endtask

   task automatic test_backpressure();
      next_cycle(); set_op(1, 1, 0, 3'b101, 32'h10, 32'h0); advance = 1'b1; #2;
      checks++; if (dbus.data_read !== 1'b1) begin errors++; $display("FAIL bp_req got=%b exp=1", dbus.data_read); end
      next_cycle(); dbus.data_resp = 1'b1; dbus.data_rdata = 32'h1234F00D; advance = 1'b0; #2;
      checks++; if (data_rdata_mem !== 32'h0000F00D || mem_busy !== 1'b0) begin
         errors++; $display("FAIL bp_resp got=%h/%b exp=0000f00d/0", data_rdata_mem, mem_busy); end
      for (int i = 0; i < 3; i++) begin
         next_cycle(); dbus.data_resp = 1'b0; dbus.data_rdata = 32'h5555AAAA; #2;
         checks++; if (mem_busy !== 1'b0 || dbus.data_read !== 1'b0 || data_rdata_mem !== 32'h0000F00D) begin
            errors++; $display("FAIL bp_hold%0d got=%b%b/%h exp=00/0000f00d", i, mem_busy, dbus.data_read, data_rdata_mem); end
      end
      next_cycle(); advance = 1'b1; #2;
      checks++; if (mem_busy !== 1'b0 || dbus.data_read !== 1'b0 || data_rdata_mem !== 32'h0000F00D) begin
         errors++; $display("FAIL bp_release got=%b%b/%h exp=00/0000f00d", mem_busy, dbus.data_read, data_rdata_mem); end
   endtask

   task automatic test_back_to_back();
      next_cycle(); set_op(1, 1, 0, 3'b001, 32'h12, 32'h0); #2;
      checks++; if (dbus.data_read !== 1'b1 || mem_busy !== 1'b1) begin
         errors++; $display("FAIL b2b_req0 got=%b%b exp=11", dbus.data_read, mem_busy); end
      next_cycle(); dbus.data_resp = 1'b1; dbus.data_rdata = 32'h80010000; #2;
      checks++; if (data_rdata_mem !== 32'hFFFF8001) begin errors++; $display("FAIL b2b_lh got=%h exp=ffff8001", data_rdata_mem); end
      next_cycle(); dbus.data_resp = 1'b0; set_op(1, 1, 0, 3'b010, 32'h20, 32'h0); #2;
      checks++; if (dbus.data_read !== 1'b1 || mem_busy !== 1'b1 || data_rdata_mem !== 32'hFFFF8001) begin
         errors++; $display("FAIL b2b_req1 got=%b%b/%h exp=11/ffff8001", dbus.data_read, mem_busy, data_rdata_mem); end
      next_cycle(); dbus.data_resp = 1'b1; dbus.data_rdata = 32'h01020304; #2;
      checks++; if (data_rdata_mem !== 32'h01020304) begin errors++; $display("FAIL b2b_lw got=%h exp=01020304", data_rdata_mem); end
      next_cycle(); dbus.data_resp = 1'b0; set_op(0, 0, 0, 3'b000, 32'h0, 32'h0);
   endtask

   task automatic test_reset_in_wait();
      next_cycle(); set_op(1, 1, 0, 3'b010, 32'h40, 32'h0); #2;
      checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL rw_busy got=%b exp=1", mem_busy); end
      next_cycle(); rst = 1'b1; #2;
      checks++; if (dbus.data_read !== 1'b0 || mem_busy !== 1'b0 || data_rdata_mem !== 32'h0) begin
         errors++; $display("FAIL rw_inrst got=%b%b/%h exp=00/0", dbus.data_read, mem_busy, data_rdata_mem); end
      next_cycle(); rst = 1'b0; set_op(0, 0, 0, 3'b000, 32'h0, 32'h0);
      dbus.data_resp = 1'b1; dbus.data_rdata = 32'hCAFEBABE; #2;
      checks++; if (dbus.data_read !== 1'b0 || mem_busy !== 1'b0 || data_rdata_mem !== 32'h0) begin
         errors++; $display("FAIL rw_late got=%b%b/%h exp=00/0", dbus.data_read, mem_busy, data_rdata_mem); end
      next_cycle(); dbus.data_resp = 1'b0; dbus.data_rdata = 32'h0; #2;
      checks++; if (data_rdata_mem !== 32'h0) begin errors++; $display("FAIL rw_nocap got=%h exp=0", data_rdata_mem); end
   endtask

`ifdef MEM_MISALIGN_CHECK_EN
   task automatic test_misalign();
      next_cycle(); set_op(1, 1, 0, 3'b010, 32'h101, 32'h0); #2;
      checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_flag got=%b exp=1", misalign); end
      checks++; if (dbus.data_read !== 1'b0 || mem_busy !== 1'b0 || data_rdata_mem !== 32'h0) begin
         errors++; $display("FAIL mis_suppress got=%b%b/%h exp=00/0", dbus.data_read, mem_busy, data_rdata_mem); end
      next_cycle(); set_op(1, 1, 0, 3'b001, 32'h102, 32'h0); #2;
      checks++; if (misalign !== 1'b0 || dbus.data_read !== 1'b1) begin
         errors++; $display("FAIL mis_ok got=%b%b exp=01", misalign, dbus.data_read); end
      next_cycle(); dbus.data_resp = 1'b1; dbus.data_rdata = 32'h7FFF0000; #2;
      checks++; if (data_rdata_mem !== 32'h00007FFF) begin errors++; $display("FAIL mis_lh got=%h exp=00007fff", data_rdata_mem); end
      next_cycle(); dbus.data_resp = 1'b0; set_op(0, 0, 0, 3'b000, 32'h0, 32'h0);
   endtask
`else
   task automatic test_truncated_lane();
      next_cycle(); set_op(1, 1, 0, 3'b101, 32'h103, 32'h0); #2;
      checks++; if (dbus.data_read !== 1'b1 || dbus.data_addr !== 32'h100) begin
         errors++; $display("FAIL trunc_req got=%b/%h exp=1/100", dbus.data_read, dbus.data_addr); end
      next_cycle(); dbus.data_resp = 1'b1; dbus.data_rdata = 32'hAB000000; #2;
      checks++; if (data_rdata_mem !== 32'h000000AB) begin errors++; $display("FAIL trunc_data got=%h exp=000000ab", data_rdata_mem); end
      next_cycle(); dbus.data_resp = 1'b0; set_op(0, 0, 0, 3'b000, 32'h0, 32'h0);
   endtask
`endif

   initial begin
      test_reset();
      test_lw();
      test_lb_lbu();
      test_store();
      test_backpressure();
      test_back_to_back();
      test_reset_in_wait();
`ifdef MEM_MISALIGN_CHECK_EN
      test_misalign();
`else
      test_truncated_lane();
`endif
      next_cycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
